// File: rtl/l1i_refill_controller.sv
// L1I miss-handling sequencer: in-order miss queue, line-aligned memory read, multi-beat line assembly.
// Optional feature macro: L1I_MISS_MERGE_EN merges misses to a line already held in the queue.
module l1i_refill_controller #(
    parameter int fetchingAddressWidth    = 64,
    parameter int cacheLineWidth          = 512,
    parameter int memBusWidth             = 128,
    parameter int offsetWidth             = 6,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int missQueueDepth          = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               cacheMiss_i,
    input  logic [fetchingAddressWidth-1:0]    missedAddress_i,
    input  logic [PidSize-1:0]                 missedPid_i,
    input  logic [TidSize-1:0]                 missedTid_i,
    input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
    output logic                               missAccept_o,
    output logic                               missOverflow_o,
    output logic                               memReq_o,
    output logic [fetchingAddressWidth-1:0]    memReqAddress_o,
    input  logic                               memReqReady_i,
    input  logic                               memResp_i,
    input  logic [memBusWidth-1:0]             memRespData_i,
    output logic                               cacheUpdate_o,
    output logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o,
    output logic [cacheLineWidth-1:0]          cacheUpdateLine_o,
    output logic [PidSize-1:0]                 cacheUpdatePid_o,
    output logic [TidSize-1:0]                 cacheUpdateTid_o,
    output logic                               fetchStall_o,
    output logic [instructionCounterWidth-1:0] refillMajorId_o
);

    localparam int BEATS  = cacheLineWidth / memBusWidth;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(missQueueDepth);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(missQueueDepth);
    localparam logic [fetchingAddressWidth-1:0] OFFSET_MASK =
        {{(fetchingAddressWidth - offsetWidth){1'b0}}, {offsetWidth{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RECV   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [PTR_W-1:0]          rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]          wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          remain;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [cacheLineWidth-1:0] line_q, line_d;

    logic [fetchingAddressWidth-1:0]    qAddr_q [missQueueDepth];
    logic [PidSize-1:0]                 qPid_q  [missQueueDepth];
    logic [TidSize-1:0]                 qTid_q  [missQueueDepth];
    logic [instructionCounterWidth-1:0] qMid_q  [missQueueDepth];

    logic [fetchingAddressWidth-1:0]    missLine;
    logic [fetchingAddressWidth-1:0]    nextHeadAddr;
    logic                               mergeHit;
    logic                               enq;
    logic                               pop;

    logic                               memReq_q;
    logic [fetchingAddressWidth-1:0]    memReqAddr_q;
    logic                               cacheUpdate_q;
    logic [fetchingAddressWidth-1:0]    updAddr_q;
    logic [cacheLineWidth-1:0]          updLine_q;
    logic [PidSize-1:0]                 updPid_q;
    logic [TidSize-1:0]                 updTid_q;
    logic [instructionCounterWidth-1:0] updMid_q;
    logic                               stall_q;
    logic                               overflow_q;

    assign missLine     = missedAddress_i & ~OFFSET_MASK;
    assign missAccept_o = (count_q < DEPTH);

`ifdef L1I_MISS_MERGE_EN
    // Every occupied slot is compared, including the head still being refilled.
    always_comb begin
        mergeHit = 1'b0;
        for (int k = 0; k < missQueueDepth; k++) begin
            if ((CNT_W'(k) < count_q) && (qAddr_q[rdPtr_q + PTR_W'(k)] == missLine)) begin
                mergeHit = 1'b1;
            end
        end
    end
`else
    assign mergeHit = 1'b0;
`endif

    assign enq     = cacheMiss_i && missAccept_o && !mergeHit;
    assign pop     = (state_q == S_UPDATE);
    assign count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    assign wrPtr_d = wrPtr_q + PTR_W'(enq);
    assign rdPtr_d = rdPtr_q + PTR_W'(pop);
    assign remain  = count_q - CNT_W'(pop);

    // After a pop that empties the stored entries, the new head is the miss written this cycle.
    assign nextHeadAddr = (remain == '0) ? missLine : qAddr_q[rdPtr_d];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (memReqReady_i) begin
                    state_d = S_RECV;
                    beat_d  = '0;
                end
            end
            S_RECV: begin
                if (memResp_i) begin
                    line_d[(BEATS - 1 - int'(beat_q)) * memBusWidth +: memBusWidth] = memRespData_i;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_UPDATE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_UPDATE: begin
                state_d = (count_d != '0) ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (enq) begin
            qAddr_q[wrPtr_q] <= missLine;
            qPid_q[wrPtr_q]  <= missedPid_i;
            qTid_q[wrPtr_q]  <= missedTid_i;
            qMid_q[wrPtr_q]  <= missedInstMajorId_i;
        end
        line_q <= line_d;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            count_q       <= '0;
            beat_q        <= '0;
            memReq_q      <= 1'b0;
            memReqAddr_q  <= '0;
            cacheUpdate_q <= 1'b0;
            updAddr_q     <= '0;
            updLine_q     <= '0;
            updPid_q      <= '0;
            updTid_q      <= '0;
            updMid_q      <= '0;
            stall_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            count_q       <= count_d;
            beat_q        <= beat_d;
            memReq_q      <= (state_d == S_REQ);
            cacheUpdate_q <= (state_d == S_UPDATE);
            stall_q       <= (count_d != '0) || (state_d != S_IDLE);
            overflow_q    <= overflow_q | (cacheMiss_i && !missAccept_o && !mergeHit);
            if (state_d == S_REQ) begin
                memReqAddr_q <= nextHeadAddr;
            end
            // Update-port fields are captured on the final beat and held until the next refill.
            if ((state_q == S_RECV) && (state_d == S_UPDATE)) begin
                updAddr_q <= qAddr_q[rdPtr_q];
                updLine_q <= line_d;
                updPid_q  <= qPid_q[rdPtr_q];
                updTid_q  <= qTid_q[rdPtr_q];
                updMid_q  <= qMid_q[rdPtr_q];
            end
        end
    end

    assign missOverflow_o       = overflow_q;
    assign memReq_o             = memReq_q;
    assign memReqAddress_o      = memReqAddr_q;
    assign cacheUpdate_o        = cacheUpdate_q;
    assign cacheUpdateAddress_o = updAddr_q;
    assign cacheUpdateLine_o    = updLine_q;
    assign cacheUpdatePid_o     = updPid_q;
    assign cacheUpdateTid_o     = updTid_q;
    assign refillMajorId_o      = updMid_q;
    assign fetchStall_o         = stall_q;

endmodule

// File: tb/tb_l1i_refill_controller.sv
// Scoreboard bench for l1i_refill_controller: expected refills queued at miss time, checked on cacheUpdate_o.
module tb_l1i_refill_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cacheMiss = 1'b0;
    logic [63:0]  missAddr = '0;
    logic [19:0]  missPid = '0;
    logic [15:0]  missTid = '0;
    logic [63:0]  missMid = '0;
    logic         missAccept, missOverflow;
    logic         memReq;
    logic [63:0]  memReqAddr;
    logic         memReqReady = 1'b0;
    logic         memResp = 1'b0;
    logic [127:0] memRespData = '0;
    logic         cacheUpdate;
    logic [63:0]  updAddr;
    logic [511:0] updLine;
    logic [19:0]  updPid;
    logic [15:0]  updTid;
    logic         fetchStall;
    logic [63:0]  refillMid;

    typedef struct packed {
        logic [63:0] addr;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [63:0] mid;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] line_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    l1i_refill_controller dut (
        .clock_i              (clk),
        .reset_i              (rst),
        .cacheMiss_i          (cacheMiss),
        .missedAddress_i      (missAddr),
        .missedPid_i          (missPid),
        .missedTid_i          (missTid),
        .missedInstMajorId_i  (missMid),
        .missAccept_o         (missAccept),
        .missOverflow_o       (missOverflow),
        .memReq_o             (memReq),
        .memReqAddress_o      (memReqAddr),
        .memReqReady_i        (memReqReady),
        .memResp_i            (memResp),
        .memRespData_i        (memRespData),
        .cacheUpdate_o        (cacheUpdate),
        .cacheUpdateAddress_o (updAddr),
        .cacheUpdateLine_o    (updLine),
        .cacheUpdatePid_o     (updPid),
        .cacheUpdateTid_o     (updTid),
        .fetchStall_o         (fetchStall),
        .refillMajorId_o      (refillMid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every update pulse against the oldest expected refill.
    always @(negedge clk) begin
        if (!rst && cacheUpdate) begin
            if (exp_q.size() == 0) begin
                chk("upd_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("upd_addr", updAddr, e.addr);
                chk("upd_pid", updPid, e.pid);
                chk("upd_tid", updTid, e.tid);
                chk("upd_mid", refillMid, e.mid);
                if (line_q.size() == 0) chk("upd_no_line", 1, 0);
                else chk("upd_line", updLine, line_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        line_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic miss(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t,
                        input logic [63:0] m, input bit accept);
        exp_t e;
        cacheMiss = 1'b1;
        missAddr  = a;
        missPid   = p;
        missTid   = t;
        missMid   = m;
        if (accept) begin
            e.addr = a & ~64'h3F;
            e.pid  = p;
            e.tid  = t;
            e.mid  = m;
            exp_q.push_back(e);
        end
        tick();
        cacheMiss = 1'b0;
    endtask

    task automatic serve(input int hold, input logic [127:0] b0, input logic [127:0] b1,
                         input logic [127:0] b2, input logic [127:0] b3, input bit junk);
        logic [127:0] beats [4];
        logic [63:0]  reqAddr;
        int           n;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        n = 0;
        while (!memReq && n < 50) begin
            tick();
            n++;
        end
        if (!memReq) begin
            chk("req_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) chk("req_unexpected", 1, 0);
        else chk("req_addr", memReqAddr, exp_q[0].addr);
        reqAddr = memReqAddr;
        for (int i = 0; i < hold; i++) begin
            memResp     = junk;
            memRespData = {4{32'hDEAD_BEEF}};
            tick();
            chk("req_hold", memReq, 1);
            chk("req_hold_addr", memReqAddr, reqAddr);
        end
        memResp     = 1'b0;
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        chk("req_drop", memReq, 0);
        for (int i = 0; i < 4; i++) begin
            memResp     = 1'b1;
            memRespData = beats[i];
            if (i == 3) line_q.push_back({b0, b1, b2, b3});
            tick();
        end
        memResp = 1'b0;
        chk("upd_latency", cacheUpdate, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] A, B, C, D;
        A = {4{32'hAAAA_0001}};
        B = {4{32'hBBBB_0002}};
        C = {4{32'hCCCC_0003}};
        D = {4{32'hDDDD_0004}};

        do_reset();
        chk("rst_req", memReq, 0);
        chk("rst_upd", cacheUpdate, 0);
        chk("rst_stall", fetchStall, 0);
        chk("rst_ovf", missOverflow, 0);
        chk("rst_accept", missAccept, 1);

        // Single refill and its latencies
        miss(64'h40, 20'h1, 16'h1, 64'h1, 1'b1);
        chk("t1_req_early", memReq, 0);
        chk("t1_stall_rise", fetchStall, 1);
        tick();
        chk("t1_req_lat", memReq, 1);
        serve(0, A, B, C, D, 1'b0);
        tick();
        chk("t1_upd_pulse", cacheUpdate, 0);
        chk("t1_stall_drop", fetchStall, 0);
        chk("t1_line_hold", updLine, {A, B, C, D});

        // Unaligned address and ID fields
        miss(64'h1234, 20'd5, 16'd3, 64'd9, 1'b1);
        serve(0, D, C, B, A, 1'b0);
        chk("t2_pid", updPid, 20'd5);
        chk("t2_tid", updTid, 16'd3);
        chk("t2_mid", refillMid, 64'd9);
        tick();

        // Queue overflow and in-order back-to-back refills
        miss(64'h00, 20'h10, 16'h10, 64'h10, 1'b1);
        miss(64'h40, 20'h11, 16'h11, 64'h11, 1'b1);
        chk("t3_full", missAccept, 0);
        miss(64'h80, 20'h12, 16'h12, 64'h12, 1'b0);
        chk("t3_ovf", missOverflow, 1);
        serve(0, A, A, B, B, 1'b0);
        tick();
        chk("t3_b2b_req", memReq, 1);
        serve(0, C, C, D, D, 1'b0);
        tick();
        chk("t3_idle", fetchStall, 0);

        // Ready held low, stray beats before acceptance
        miss(64'h2C0, 20'h7, 16'h7, 64'h7, 1'b1);
        serve(5, B, D, A, C, 1'b1);
        chk("t4_ovf_sticky", missOverflow, 1);
        tick();

        // Reset in the middle of a refill
        miss(64'h100, 20'h8, 16'h8, 64'h8, 1'b1);
        tick();
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        memResp = 1'b1; memRespData = A; tick();
        memResp = 1'b1; memRespData = B; tick();
        rst = 1'b1;
        exp_q.delete();
        line_q.delete();
        memRespData = C;
        tick();
        chk("t5_req", memReq, 0);
        chk("t5_req_addr", memReqAddr, 0);
        chk("t5_upd", cacheUpdate, 0);
        chk("t5_line", updLine, 0);
        chk("t5_upd_addr", updAddr, 0);
        chk("t5_stall", fetchStall, 0);
        chk("t5_ovf", missOverflow, 0);
        rst = 1'b0;
        memRespData = D;
        tick();
        memResp = 1'b0;
        tick();
        tick();
        chk("t5_quiet_req", memReq, 0);
        chk("t5_quiet_stall", fetchStall, 0);
        miss(64'h80, 20'h9, 16'h9, 64'h9, 1'b1);
        serve(0, C, D, A, B, 1'b0);
        tick();

        // Same-line misses
`ifdef L1I_MISS_MERGE_EN
        miss(64'h40, 20'h21, 16'h21, 64'h21, 1'b1);
        miss(64'h44, 20'h22, 16'h22, 64'h22, 1'b0);
        serve(0, A, C, B, D, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_no_second_req", memReq, 0);
        chk("t6_no_ovf", missOverflow, 0);
`else
        miss(64'h40, 20'h21, 16'h21, 64'h21, 1'b1);
        miss(64'h44, 20'h22, 16'h22, 64'h22, 1'b1);
        serve(0, A, C, B, D, 1'b0);
        serve(0, D, B, C, A, 1'b0);
        tick();
        chk("t6_no_ovf", missOverflow, 0);
`endif
        tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
